// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage types and constants: widths, decode field positions, queue entry.
package fetch_stage_pkg;

  localparam int XLEN     = 64;
  localparam logic [XLEN-1:0] RESET_PC = 64'h0;
  localparam int INSTR_W  = 32;

  localparam int OPCODE_LSB = 0;
  localparam int OPCODE_MSB = 6;
  localparam int FUNCT3_LSB = 12;
  localparam int FUNCT3_MSB = 14;
  localparam int FUNCT7_LSB = 25;
  localparam int FUNCT7_MSB = 31;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetch entries; DEPTH must be a power of two.
module fetch_queue
  import fetch_stage_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  fetch_entry_t  data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output fetch_entry_t  head_o,
  output logic [CW-1:0] count_o,
  output logic          empty_o,
  output logic          full_o
);

  fetch_entry_t  mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign head_o  = mem_q[rd_q];
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else if (flush_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (do_push) wr_q <= wr_q + AW'(1);
      if (do_pop)  rd_q <= rd_q + AW'(1);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  // Storage needs no reset: the count alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_q] <= data_i;
  end

  a_no_overflow : assert property (@(posedge clk) disable iff (reset)
    !(push_i && full_o && !do_pop && !flush_i));

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, credit-limited imem requests, fetch queue and IF/ID register.
// Optional macro FETCH_MISALIGN_TRAP_EN: misaligned redirect raises a sticky fault and blocks fetch.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int              XLEN     = fetch_stage_pkg::XLEN,
  parameter logic [XLEN-1:0] RESET_PC = fetch_stage_pkg::RESET_PC,
  parameter int              QDEPTH   = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req_valid,
  output logic [XLEN-1:0]    imem_req_addr,
  input  logic               imem_req_ready,
  input  logic               imem_resp_valid,
  input  logic [INSTR_W-1:0] imem_resp_data,
  input  logic               redirect_valid,
  input  logic [XLEN-1:0]    redirect_pc,
  input  logic               stall,
  output logic               id_valid,
  output logic [INSTR_W-1:0] id_instr,
  output logic [XLEN-1:0]    id_pc,
  output logic [6:0]         id_opcode,
  output logic [2:0]         id_funct3,
  output logic [6:0]         id_funct7,
  output logic               misalign_fault
);

  localparam int CW = $clog2(QDEPTH + 1);

  logic [XLEN-1:0]    pc_q, pc_d, tag_q, tag_d, redirect_tgt;
  logic [CW-1:0]      out_q, out_d, drop_q, drop_d, q_count;
  logic               id_valid_q, id_valid_d;
  logic [INSTR_W-1:0] id_instr_q, id_instr_d;
  logic [XLEN-1:0]    id_pc_q, id_pc_d;
  logic               accept, q_push, q_pop, q_empty, q_full, fault_q;
  fetch_entry_t       q_head, q_wdata;

  assign accept  = imem_req_valid && imem_req_ready;
  assign q_pop   = !stall && !q_empty;
  assign q_push  = imem_resp_valid && (drop_q == '0) && !redirect_valid;
  // tag_q is the PC of the oldest response that will be kept
  assign q_wdata = '{pc: tag_q, instr: imem_resp_data};

  // The head leaving this cycle frees its slot, so a 1-cycle memory sustains one word per cycle.
  assign imem_req_valid = !reset && !fault_q &&
                          ((int'(out_q) + int'(q_count) - int'(q_pop)) < QDEPTH);
  assign imem_req_addr  = pc_q;

`ifdef FETCH_MISALIGN_TRAP_EN
  logic fault_d;
  assign redirect_tgt = redirect_pc;
  always_comb begin
    fault_d = fault_q;
    if (redirect_valid) fault_d = |redirect_pc[1:0];
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) fault_q <= 1'b0;
    else       fault_q <= fault_d;
  end
`else
  logic unused_align;
  assign redirect_tgt = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_align = ^redirect_pc[1:0];
  assign fault_q      = 1'b0;
`endif

  always_comb begin
    pc_d       = pc_q;
    tag_d      = tag_q;
    drop_d     = drop_q;
    out_d      = out_q + CW'(accept) - CW'(imem_resp_valid);
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc_d    = id_pc_q;
    if (accept) pc_d = pc_q + XLEN'(4);
    if (imem_resp_valid) begin
      if (drop_q != '0) drop_d = drop_q - CW'(1);
      else              tag_d  = tag_q + XLEN'(4);
    end
    if (!stall) begin
      if (!q_empty) begin
        id_valid_d = 1'b1;
        id_instr_d = q_head.instr;
        id_pc_d    = q_head.pc;
      end else begin
        id_valid_d = 1'b0;
      end
    end
    // Everything still in flight after this cycle belongs to the old path.
    if (redirect_valid) begin
      pc_d       = redirect_tgt;
      tag_d      = redirect_tgt;
      drop_d     = out_d;
      id_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      tag_q      <= RESET_PC;
      out_q      <= '0;
      drop_q     <= '0;
      id_valid_q <= 1'b0;
      id_instr_q <= '0;
      id_pc_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      tag_q      <= tag_d;
      out_q      <= out_d;
      drop_q     <= drop_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc_q    <= id_pc_d;
    end
  end

  fetch_queue #(.DEPTH(QDEPTH)) u_queue (
    .clk     (clk),
    .reset   (reset),
    .push_i  (q_push),
    .data_i  (q_wdata),
    .pop_i   (q_pop),
    .flush_i (redirect_valid),
    .head_o  (q_head),
    .count_o (q_count),
    .empty_o (q_empty),
    .full_o  (q_full)
  );

  assign id_valid       = id_valid_q;
  assign id_instr       = id_instr_q;
  assign id_pc          = id_pc_q;
  assign id_opcode      = id_instr_q[OPCODE_MSB:OPCODE_LSB];
  assign id_funct3      = id_instr_q[FUNCT3_MSB:FUNCT3_LSB];
  assign id_funct7      = id_instr_q[FUNCT7_MSB:FUNCT7_LSB];
  assign misalign_fault = fault_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios then randomized traffic vs. a stream model.
module tb_fetch_stage;

  localparam int QDEPTH = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid, imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        stall;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [6:0]  id_opcode, id_funct7;
  logic [2:0]  id_funct3;
  logic        misalign_fault;

  fetch_stage #(.QDEPTH(QDEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr), .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc(id_pc),
    .id_opcode(id_opcode), .id_funct3(id_funct3), .id_funct7(id_funct7),
    .misalign_fault(misalign_fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] addr;
    int          due;
  } req_t;

  req_t        pending[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc, lat;
  logic [63:0] m_pc, m_next_id;
  logic        m_fault;
  logic        p_stall, p_redirect, p_valid;
  logic [63:0] p_pc;
  logic [31:0] p_instr;
  logic        s_req_valid, s_id_valid, s_resp, s_accept;
  logic [63:0] s_id_pc;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [63:0] a);
    return {a[15:0], ~a[17:2]} ^ 32'h1357_9bdf;
  endfunction

  function automatic logic [63:0] eff_tgt(input logic [63:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
    return t;
`else
    return {t[63:2], 2'b00};
`endif
  endfunction

  // One clock cycle: memory drives its response, outputs are judged at the falling edge,
  // then the reference model advances just after the rising edge.
  task automatic tick();
    logic        rd;
    logic [63:0] rt;
    logic [31:0] ei;
    int          due;
    if (pending.size() > 0 && pending[0].due <= cyc) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = word_of(pending[0].addr);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = $urandom;
    end
    @(negedge clk);
    s_req_valid = imem_req_valid;
    s_id_valid  = id_valid;
    s_id_pc     = id_pc;
    s_resp      = imem_resp_valid;
    s_accept    = imem_req_valid && imem_req_ready;
    check("fault", misalign_fault, m_fault);
    if (m_fault) check("blocked", imem_req_valid, 0);
    check("req_addr", imem_req_addr, m_pc);
    check("credit", pending.size() <= QDEPTH, 1);
    if (p_redirect) begin
      check("flush", id_valid, 0);
    end else if (p_stall) begin
      check("hold_v", id_valid, p_valid);
      if (p_valid) begin
        check("hold_pc", id_pc, p_pc);
        check("hold_instr", id_instr, p_instr);
      end
    end else if (id_valid) begin
      ei = word_of(m_next_id);
      check("id_pc", id_pc, m_next_id);
      check("id_instr", id_instr, ei);
      check("opcode", id_opcode, ei[6:0]);
      check("funct3", id_funct3, ei[14:12]);
      check("funct7", id_funct7, ei[31:25]);
      m_next_id = m_next_id + 64'd4;
    end
    p_valid    = id_valid;
    p_pc       = id_pc;
    p_instr    = id_instr;
    p_stall    = stall;
    p_redirect = redirect_valid;
    rd         = redirect_valid;
    rt         = redirect_pc;
    @(posedge clk);
    #1;
    if (s_resp) void'(pending.pop_front());
    if (s_accept) begin
      due = cyc + lat;
      if (pending.size() > 0 && due < pending[$].due) due = pending[$].due;
      pending.push_back('{addr: m_pc, due: due});
      m_pc = m_pc + 64'd4;
    end
    if (rd) begin
      m_pc      = eff_tgt(rt);
      m_next_id = eff_tgt(rt);
`ifdef FETCH_MISALIGN_TRAP_EN
      m_fault = |rt[1:0];
`endif
    end
    cyc++;
  endtask

  task automatic do_reset();
    reset          = 1'b1;
    imem_req_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    stall          = 1'b0;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    pending.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_id_valid", id_valid, 0);
    check("rst_id_instr", id_instr, 0);
    check("rst_id_pc", id_pc, 0);
    check("rst_req_valid", imem_req_valid, 0);
    check("rst_fault", misalign_fault, 0);
    @(posedge clk);
    #1;
    reset      = 1'b0;
    cyc        = 0;
    lat        = 1;
    m_pc       = 64'h0;
    m_next_id  = 64'h0;
    m_fault    = 1'b0;
    p_stall    = 1'b0;
    p_redirect = 1'b0;
    p_valid    = 1'b0;
  endtask

  task automatic redirect_to(input logic [63:0] t);
    redirect_valid = 1'b1;
    redirect_pc    = t;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_id(input string tag, input logic [63:0] exp, input int limit);
    for (int n = 0; n < limit; n++) begin
      tick();
      if (s_id_valid) break;
    end
    check({tag, "_v"}, s_id_valid, 1);
    check(tag, s_id_pc, exp);
  endtask

  initial begin
    do_reset();

    // Cold start with 1-cycle memory: request every cycle, first instruction 3 cycles in.
    for (int k = 0; k < 10; k++) begin
      tick();
      check("t1_req", s_req_valid, 1);
      check("t1_idv", s_id_valid, k >= 3);
      if (k >= 3) check("t1_pc", s_id_pc, 64'(4 * (k - 3)));
    end

    stall = 1'b1;
    repeat (4) tick();
    stall = 1'b0;
    repeat (6) tick();

    // Build up two outstanding requests with slow memory, then redirect.
    lat = 3;
    repeat (6) tick();
    redirect_to(64'h100);
    lat = 1;
    wait_id("t3_pc", 64'h100, 12);
    repeat (4) tick();

    // Redirect in a cycle that also accepts a request and receives a response.
    redirect_valid = 1'b1;
    redirect_pc    = 64'h300;
    tick();
    redirect_valid = 1'b0;
    check("t4_acc", s_accept, 1);
    check("t4_resp", s_resp, 1);
    wait_id("t4_pc", 64'h300, 8);
    repeat (3) tick();

    imem_req_ready = 1'b0;
    repeat (5) tick();
    check("t5_drain", s_id_valid, 0);
    imem_req_ready = 1'b1;
    repeat (4) tick();

    redirect_to(64'h102);
`ifdef FETCH_MISALIGN_TRAP_EN
    repeat (4) tick();
    check("t6_fault", s_req_valid, 0);
    redirect_to(64'h200);
    wait_id("t6_resume", 64'h200, 8);
`else
    wait_id("t6_align", 64'h100, 8);
`endif

    for (int n = 0; n < 600; n++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      stall          = ($urandom_range(0, 3) == 0);
      lat            = $urandom_range(1, 3);
      if ($urandom_range(0, 24) == 0) begin
        redirect_valid = 1'b1;
        redirect_pc    = (64'($urandom_range(0, 4095)) << 2) |
                         (($urandom_range(0, 3) == 0) ? 64'($urandom_range(1, 3)) : 64'h0);
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
    end
    redirect_valid = 1'b0;
    stall          = 1'b0;
    imem_req_ready = 1'b1;
    repeat (6) tick();

    // Asynchronous reset mid-stream clears the IF/ID register without waiting for an edge.
    #2;
    reset = 1'b1;
    #1;
    check("arst_idv", id_valid, 0);
    check("arst_req", imem_req_valid, 0);
    do_reset();
    tick();
    check("rerun_req", s_req_valid, 1);
    wait_id("rerun_pc", 64'h0, 6);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
